tcp_pkt_serializer: RTL and testbench
=====================================

// Module: tcp_pkt_serializer
// PURPOSE
//  Downstream stage of the TCP client controller. Takes the 224-bit packet the controller drives each cycle.
//  Discards the all-ones idle pattern. Latches real packets and serializes them as seven 32-bit words over a
//  valid/ready stream toward the link/MAC side. Optionally fills in the TCP checksum field before sending.
// PARAMETERS
//  PKT_W    224  packet width; fixed at 224 (7 words), other values unsupported
//  WORD_W   32   output word width
//  CNT_W    16   width of the sent and dropped packet counters
// PORTS
//  clk         in   1      clock, all logic on posedge
//  rst         in   1      asynchronous, active-low reset
//  pkt_in      in   224    packet from the TCP client controller (field map as in tcp_pkg)
//  pkt_valid   in   1      pkt_in is valid this cycle
//  pkt_ready   out  1      serializer can accept pkt_in this cycle
//  word_data   out  32     serialized word
//  word_valid  out  1      word_data is valid
//  word_ready  in   1      sink accepts word_data
//  word_last   out  1      current word is word 6 (bits 223:192)
//  word_idx    out  3      index of the current word, 0..6
//  sent_cnt    out  CNT_W  packets fully sent; wraps at 2^CNT_W
//  drop_cnt    out  CNT_W  idle patterns discarded; wraps at 2^CNT_W
// BEHAVIOUR
//  Reset (rst=0, takes effect immediately):
//   - state=IDLE, pkt_ready=1, word_valid=0, word_last=0, word_idx=0, word_data=0, sent_cnt=0, drop_cnt=0
//   - a packet in flight is dropped and not counted
//  FSM states: IDLE, CALC (only with the macro), SEND.
//  IDLE:
//   - pkt_ready=1
//   - on pkt_valid with pkt_in==IDLE_PATTERN (224'h all ones): drop_cnt+1, stay IDLE
//   - on pkt_valid with any other pkt_in: latch into buffer, go to SEND (or CALC)
//  SEND:
//   - pkt_ready=0; word_valid=1
//   - word_data=buf[32*word_idx+31 : 32*word_idx]; word 0 = bits 31:0 is sent first
//   - a word transfers on word_valid && word_ready; word_idx then increments
//   - while word_ready=0, word_data, word_idx and word_last hold stable
//   - transfer with word_idx==6: sent_cnt+1, word_idx=0, go IDLE, word_valid=0 next cycle
//  Latency: packet accepted at edge N -> word 0 valid from cycle N+1. Minimum 8 cycles per packet
//   (7 words + 1 IDLE cycle).
//  pkt_valid while pkt_ready=0 is ignored. The upstream controller re-presents every cycle, so no stall
//   is propagated.
//  Counters wrap from 2^CNT_W-1 to 0 silently. sent_cnt and drop_cnt never increment in the same cycle.
// CONFIGURATION
//  TCP_SER_CSUM_EN defined:
//   - after latch, go to CALC for 14 cycles, adding one 16-bit halfword per cycle (halfword 0 = bits 15:0)
//   - the sum covers halfwords 0..13, with halfword 9 (checksum, bits 159:144) taken as 0
//   - 16-bit one's-complement addition with end-around carry
//   - at the end of CALC, buf[159:144] = ~sum, then go to SEND
//   - word 0 is valid at N+15
//  TCP_SER_CSUM_EN undefined:
//   - no CALC state; bits 159:144 pass through unchanged
// STRUCTURE
//  Package tcp_pkg:
//   - field localparams: TCP_DEST_PORT..TCP_DATA bit positions, TCP_CHECKSUM_LO=144, TCP_CHECKSUM_HI=159
//   - PKT_W, WORD_W, NUM_WORDS=7, IDLE_PATTERN, state encodings
//  Sub-module tcp_csum16_acc (only with the macro):
//   - ports: clr, add_en, din[15:0], sum[15:0]
//   - one's-complement accumulator
// TESTING
//  1. Reset with rst=0 mid-SEND (word_idx=3), then release
//     -> word_valid=0, word_idx=0, sent_cnt=0, pkt_ready=1 immediately.
//  2. pkt_in=IDLE_PATTERN, pkt_valid=1 for 5 cycles
//     -> drop_cnt=5, word_valid never asserted.
//  3. pkt_in words 0..6 = 32'h0000_0000..32'h0000_0006 (macro off), word_ready=1
//     -> 7 consecutive words 0..6, word_last only on word 6, sent_cnt=1.
//  4. Same packet, word_ready toggled 1,0,0,1...
//     -> each word held stable while word_ready=0, no word lost or duplicated, pkt_ready=0 throughout.
//  5. Macro on, pkt_in all zero except bits 15:0=16'h0001
//     -> word 4 bits 31:16 = 16'hFFFE, word 0 valid 15 cycles after accept.
//  6. sent_cnt preloaded via force to 16'hFFFF, then send one packet
//     -> sent_cnt=0.

Source files
------------

// File: rtl/tcp_pkg.sv
// -----------------------------------------------------------------------------
// tcp_pkg
// Shared definitions for the TCP packet serializer slice: the field map of the
// 224-bit packet produced by the TCP client controller, the stream geometry,
// the idle pattern the controller drives when it has nothing to send, the FSM
// state encoding and a 16-bit one's-complement adder.
// Optional feature macro used by the slice: TCP_SER_CSUM_EN.
// -----------------------------------------------------------------------------
package tcp_pkg;

    // Stream geometry
    localparam int PKT_W     = 224;
    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = PKT_W / WORD_W;   // 7
    localparam int HW_W      = 16;
    localparam int NUM_HW    = 14;               // halfwords covered by the checksum

    // Packet field map (bit positions inside pkt_in)
    localparam int TCP_DEST_PORT_LO = 0;
    localparam int TCP_DEST_PORT_HI = 15;
    localparam int TCP_SRC_PORT_LO  = 16;
    localparam int TCP_SRC_PORT_HI  = 31;
    localparam int TCP_SEQ_LO       = 32;
    localparam int TCP_SEQ_HI       = 63;
    localparam int TCP_ACK_LO       = 64;
    localparam int TCP_ACK_HI       = 95;
    localparam int TCP_FLAGS_LO     = 96;
    localparam int TCP_FLAGS_HI     = 111;
    localparam int TCP_WINDOW_LO    = 112;
    localparam int TCP_WINDOW_HI    = 127;
    localparam int TCP_URGENT_LO    = 128;
    localparam int TCP_URGENT_HI    = 143;
    localparam int TCP_CHECKSUM_LO  = 144;
    localparam int TCP_CHECKSUM_HI  = 159;
    localparam int TCP_DATA_LO      = 160;
    localparam int TCP_DATA_HI      = 223;

    // Halfword index holding the checksum field (treated as zero when summing)
    localparam int TCP_CHECKSUM_HW  = TCP_CHECKSUM_LO / HW_W;   // 9

    // Pattern driven by the controller on cycles with no real packet
    localparam logic [PKT_W-1:0] IDLE_PATTERN = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SEND = 2'd2
    } ser_state_t;

    // 16-bit one's-complement addition with end-around carry. When the carry
    // is set the low part is at most 16'hFFFE, so folding it back cannot
    // overflow again.
    function automatic logic [15:0] ones_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/tcp_csum16_acc.sv
// -----------------------------------------------------------------------------
// tcp_csum16_acc
// 16-bit one's-complement accumulator used to build the TCP checksum.
// Only compiled when TCP_SER_CSUM_EN is defined.
// Ports:
//   clk     in   clock, posedge
//   rst     in   asynchronous active-low reset
//   clr     in   restart the sum; together with add_en the sum restarts at din
//   add_en  in   add din into the running sum
//   din     in   16-bit halfword
//   sum     out  running one's-complement sum
// -----------------------------------------------------------------------------
`ifdef TCP_SER_CSUM_EN
module tcp_csum16_acc
    import tcp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        add_en,
    input  logic [15:0] din,
    output logic [15:0] sum
);

    logic [15:0] sum_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_reg <= '0;
        end else if (clr) begin
            // Loading din on clear lets the first halfword be absorbed on the
            // same edge that latches the packet.
            sum_reg <= add_en ? din : 16'd0;
        end else if (add_en) begin
            sum_reg <= ones_add16(sum_reg, din);
        end
    end

    assign sum = sum_reg;

endmodule
`endif

// File: rtl/tcp_pkt_serializer.sv
// -----------------------------------------------------------------------------
// tcp_pkt_serializer
// Downstream stage of the TCP client controller. Drops the all-ones idle
// pattern, latches real packets and emits them as seven 32-bit words (word 0 =
// bits 31:0 first) on a valid/ready stream. With TCP_SER_CSUM_EN defined the
// TCP checksum field (bits 159:144) is computed over halfwords 0..13 and
// written into the packet before it is sent; otherwise it passes unchanged.
// Ports:
//   clk         in   clock, posedge
//   rst         in   asynchronous active-low reset
//   pkt_in      in   224-bit packet from the controller
//   pkt_valid   in   pkt_in valid this cycle
//   pkt_ready   out  packet can be accepted this cycle
//   word_data   out  serialized word
//   word_valid  out  word_data valid
//   word_ready  in   sink accepts word_data
//   word_last   out  current word is word 6
//   word_idx    out  index of current word, 0..6
//   sent_cnt    out  packets fully sent (wraps)
//   drop_cnt    out  idle patterns discarded (wraps)
// -----------------------------------------------------------------------------
module tcp_pkt_serializer
    import tcp_pkg::*;
#(
    parameter int PKT_W  = 224,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PKT_W-1:0]  pkt_in,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last,
    output logic [2:0]        word_idx,
    output logic [CNT_W-1:0]  sent_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

    ser_state_t         state_reg;
    logic [PKT_W-1:0]   pkt_buf_reg;
    logic [WORD_W-1:0]  word_data_reg;
    logic               word_valid_reg;
    logic               word_last_reg;
    logic [2:0]         word_idx_reg;
    logic               pkt_ready_reg;
    logic [CNT_W-1:0]   sent_cnt_reg;
    logic [CNT_W-1:0]   drop_cnt_reg;

    logic               word_xfer;
    logic               is_idle_pat;
    logic [2:0]         word_idx_next;
    logic [WORD_W-1:0]  buf_words [NUM_WORDS];

    assign word_xfer     = word_valid_reg && word_ready;
    assign is_idle_pat   = (pkt_in == IDLE_PATTERN);
    assign word_idx_next = word_idx_reg + 3'd1;

    // Word view of the packet buffer
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_words
            assign buf_words[gi] = pkt_buf_reg[gi*WORD_W +: WORD_W];
        end
    endgenerate

`ifdef TCP_SER_CSUM_EN
    localparam logic [3:0] HW_DONE = 4'(NUM_HW);
    localparam logic [3:0] HW_CSUM = 4'(TCP_CHECKSUM_HW);

    // hw_idx_reg names the next halfword to add; halfword 0 is taken straight
    // from pkt_in on the latch edge, so CALC starts at 1 and finalises at 14.
    logic [3:0]  hw_idx_reg;
    logic        csum_clr;
    logic        csum_add;
    logic [15:0] csum_din;
    logic [15:0] csum_sum;
    logic [15:0] buf_hw [NUM_HW];

    generate
        for (gi = 0; gi < NUM_HW; gi++) begin : g_halfwords
            assign buf_hw[gi] = pkt_buf_reg[gi*HW_W +: HW_W];
        end
    endgenerate

    assign csum_clr = (state_reg == ST_IDLE);
    assign csum_add = (state_reg == ST_IDLE) ? (pkt_valid && !is_idle_pat)
                                             : ((state_reg == ST_CALC) && (hw_idx_reg != HW_DONE));

    always_comb begin
        csum_din = '0;
        if (state_reg == ST_IDLE) begin
            csum_din = pkt_in[15:0];
        end else if ((hw_idx_reg < HW_DONE) && (hw_idx_reg != HW_CSUM)) begin
            csum_din = buf_hw[hw_idx_reg];
        end
    end

    tcp_csum16_acc u_csum (
        .clk    (clk),
        .rst    (rst),
        .clr    (csum_clr),
        .add_en (csum_add),
        .din    (csum_din),
        .sum    (csum_sum)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            pkt_buf_reg    <= '0;
            word_data_reg  <= '0;
            word_valid_reg <= 1'b0;
            word_last_reg  <= 1'b0;
            word_idx_reg   <= 3'd0;
            pkt_ready_reg  <= 1'b1;
            sent_cnt_reg   <= '0;
            drop_cnt_reg   <= '0;
`ifdef TCP_SER_CSUM_EN
            hw_idx_reg     <= 4'd0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pkt_valid) begin
                        if (is_idle_pat) begin
                            drop_cnt_reg <= drop_cnt_reg + 1'b1;
                        end else begin
                            pkt_buf_reg   <= pkt_in;
                            pkt_ready_reg <= 1'b0;
                            word_idx_reg  <= 3'd0;
                            word_last_reg <= 1'b0;
`ifdef TCP_SER_CSUM_EN
                            state_reg     <= ST_CALC;
                            hw_idx_reg    <= 4'd1;
`else
                            state_reg      <= ST_SEND;
                            word_valid_reg <= 1'b1;
                            word_data_reg  <= pkt_in[WORD_W-1:0];
`endif
                        end
                    end
                end
`ifdef TCP_SER_CSUM_EN
                ST_CALC: begin
                    if (hw_idx_reg == HW_DONE) begin
                        // Word 0 does not overlap the checksum field, so it
                        // can be loaded from the buffer on this same edge.
                        pkt_buf_reg[TCP_CHECKSUM_HI:TCP_CHECKSUM_LO] <= ~csum_sum;
                        state_reg      <= ST_SEND;
                        word_valid_reg <= 1'b1;
                        word_data_reg  <= buf_words[0];
                    end else begin
                        hw_idx_reg <= hw_idx_reg + 4'd1;
                    end
                end
`endif
                ST_SEND: begin
                    if (word_xfer) begin
                        if (word_last_reg) begin
                            state_reg      <= ST_IDLE;
                            sent_cnt_reg   <= sent_cnt_reg + 1'b1;
                            word_valid_reg <= 1'b0;
                            word_last_reg  <= 1'b0;
                            word_idx_reg   <= 3'd0;
                            word_data_reg  <= '0;
                            pkt_ready_reg  <= 1'b1;
                        end else begin
                            word_idx_reg  <= word_idx_next;
                            word_data_reg <= buf_words[word_idx_next];
                            word_last_reg <= (word_idx_next == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_reg      <= ST_IDLE;
                    word_valid_reg <= 1'b0;
                    pkt_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign pkt_ready  = pkt_ready_reg;
    assign word_data  = word_data_reg;
    assign word_valid = word_valid_reg;
    assign word_last  = word_last_reg;
    assign word_idx   = word_idx_reg;
    assign sent_cnt   = sent_cnt_reg;
    assign drop_cnt   = drop_cnt_reg;

endmodule

// File: tb/tb_tcp_pkt_serializer.sv
// -----------------------------------------------------------------------------
// tb_tcp_pkt_serializer
// Self-checking bench for tcp_pkt_serializer. Expected words come from a
// packet-level model: the packet itself, with the checksum field recomputed by
// plain integer summation and carry folding when TCP_SER_CSUM_EN is defined.
// -----------------------------------------------------------------------------
module tb_tcp_pkt_serializer;
    import tcp_pkg::*;

`ifdef TCP_SER_CSUM_EN
    localparam int EXP_LAT = 15;
`else
    localparam int EXP_LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [223:0] pkt_in = '0;
    logic         pkt_valid = 1'b0;
    logic         pkt_ready;
    logic [31:0]  word_data;
    logic         word_valid;
    logic         word_ready = 1'b0;
    logic         word_last;
    logic [2:0]   word_idx;
    logic [15:0]  sent_cnt;
    logic [15:0]  drop_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference counters
    logic [15:0] ref_sent = '0;
    logic [15:0] ref_drop = '0;

    // Capture of one packet transfer
    logic [31:0] cap_word [7];
    logic [2:0]  cap_idx  [7];
    logic        cap_last [7];
    int          cap_n, cap_latency, cap_unstable, cap_rdy_bad, cap_cycles;
    bit          cap_timeout;

    tcp_pkt_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .pkt_in     (pkt_in),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_last  (word_last),
        .word_idx   (word_idx),
        .sent_cnt   (sent_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [223:0] rand_pkt();
        logic [223:0] p;
        for (int i = 0; i < 7; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    // What the sink should receive for a given accepted packet
    function automatic logic [223:0] expected_pkt(input logic [223:0] p);
        logic [223:0] e;
        e = p;
`ifdef TCP_SER_CSUM_EN
        begin
            int unsigned s;
            logic [15:0] folded;
            s = 0;
            for (int h = 0; h < 14; h++) if (h != 9) s += p[h*16 +: 16];
            while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
            folded = s[15:0];
            e[159:144] = ~folded;
        end
`endif
        return e;
    endfunction

    // Offers pkt for one cycle (DUT must be idle), then drives word_ready per
    // rmode (0: always, 1: 1,0,0 repeating, 2: random) until 7 words move.
    // noise keeps presenting junk packets while busy; they must be ignored.
    task automatic run_packet(input logic [223:0] pkt, input int rmode, input bit noise);
        int          cyc;
        logic        rdy;
        logic        hold;
        logic [31:0] hold_data;
        logic [2:0]  hold_idx;
        logic        hold_last;
        cap_n = 0; cap_latency = -1; cap_unstable = 0; cap_rdy_bad = 0; cap_timeout = 0;
        pkt_in = pkt; pkt_valid = 1'b1; word_ready = 1'b0;
        @(negedge clk);
        cyc = 1; hold = 1'b0; hold_data = '0; hold_idx = '0; hold_last = 1'b0;
        while (cap_n < 7 && cyc < 200) begin
            if (word_valid === 1'b1 && cap_latency < 0) cap_latency = cyc;
            if (pkt_ready !== 1'b0) cap_rdy_bad++;
            if (hold && (word_valid !== 1'b1 || word_data !== hold_data ||
                         word_idx !== hold_idx || word_last !== hold_last)) cap_unstable++;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc - 1) % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            word_ready = rdy;
            if (noise) begin
                pkt_valid = 1'($urandom_range(0, 1));
                pkt_in    = ($urandom_range(0, 1) == 0) ? IDLE_PATTERN : rand_pkt();
            end else begin
                pkt_valid = 1'b0;
            end
            if (word_valid === 1'b1 && rdy) begin
                cap_word[cap_n] = word_data;
                cap_idx[cap_n]  = word_idx;
                cap_last[cap_n] = word_last;
                cap_n++;
            end
            hold      = (word_valid === 1'b1) && !rdy;
            hold_data = word_data;
            hold_idx  = word_idx;
            hold_last = word_last;
            @(negedge clk);
            cyc++;
        end
        cap_cycles = cyc;
        word_ready = 1'b0;
        pkt_valid  = 1'b0;
        if (cap_n < 7) cap_timeout = 1'b1;
        ref_sent = ref_sent + 16'd1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({word_valid, word_last, word_idx, pkt_ready} !== 6'b00_000_1 || word_data !== 32'd0)
            $display("FAIL reset_outputs: valid=%b last=%b idx=%0d ready=%b data=%h, required 0 0 0 1 0",
                     word_valid, word_last, word_idx, pkt_ready, word_data);
        else pass_cnt++;
        chk_cnt++;
        if (sent_cnt !== 16'd0 || drop_cnt !== 16'd0)
            $display("FAIL reset_counters: sent=%0d drop=%0d, required 0 0", sent_cnt, drop_cnt);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        $display("reset: released");
    endtask

    task automatic test_drop();
        int bad_valid;
        bad_valid = 0;
        pkt_in = IDLE_PATTERN;
        pkt_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (word_valid !== 1'b0) bad_valid++;
        end
        pkt_valid = 1'b0;
        @(negedge clk);
        if (word_valid !== 1'b0) bad_valid++;
        ref_drop = ref_drop + 16'd5;
        chk_cnt++;
        if (drop_cnt !== ref_drop) $display("FAIL drop_cnt: got %0d, required %0d", drop_cnt, ref_drop);
        else pass_cnt++;
        chk_cnt++;
        if (bad_valid != 0) $display("FAIL drop_no_valid: word_valid high in %0d cycles, required 0", bad_valid);
        else pass_cnt++;
        $display("drop: 5 idle patterns, drop_cnt=%0d", drop_cnt);
    endtask

    task automatic test_sequential();
        logic [223:0] p, e;
        for (int k = 0; k < 7; k++) p[k*32 +: 32] = k;
        e = expected_pkt(p);
        run_packet(p, 0, 1'b0);
        chk_cnt++;
        if (cap_timeout) $display("FAIL seq_timeout: got %0d words, required 7", cap_n);
        else pass_cnt++;
        for (int k = 0; k < cap_n; k++) begin
            chk_cnt++;
            if (cap_word[k] !== e[k*32 +: 32] || cap_idx[k] !== 3'(k) || cap_last[k] !== (k == 6))
                $display("FAIL seq_word%0d: data=%h idx=%0d last=%b, required %h %0d %b",
                         k, cap_word[k], cap_idx[k], cap_last[k], e[k*32 +: 32], k, (k == 6));
            else pass_cnt++;
        end
        chk_cnt++;
        if (cap_latency != EXP_LAT) $display("FAIL seq_latency: got %0d, required %0d", cap_latency, EXP_LAT);
        else pass_cnt++;
        chk_cnt++;
        if (cap_cycles != EXP_LAT + 7) $display("FAIL seq_cycles: got %0d, required %0d", cap_cycles, EXP_LAT + 7);
        else pass_cnt++;
        chk_cnt++;
        if (sent_cnt !== ref_sent || word_valid !== 1'b0 || pkt_ready !== 1'b1)
            $display("FAIL seq_end: sent=%0d valid=%b ready=%b, required %0d 0 1", sent_cnt, word_valid, pkt_ready, ref_sent);
        else pass_cnt++;
        $display("sequential: %0d words, latency %0d, sent_cnt=%0d", cap_n, cap_latency, sent_cnt);
    endtask

    task automatic test_backpressure();
        logic [223:0] p, e;
        for (int k = 0; k < 7; k++) p[k*32 +: 32] = k;
        e = expected_pkt(p);
        run_packet(p, 1, 1'b1);
        chk_cnt++;
        if (cap_timeout) $display("FAIL bp_timeout: got %0d words, required 7", cap_n);
        else pass_cnt++;
        for (int k = 0; k < cap_n; k++) begin
            chk_cnt++;
            if (cap_word[k] !== e[k*32 +: 32] || cap_idx[k] !== 3'(k))
                $display("FAIL bp_word%0d: data=%h idx=%0d, required %h %0d", k, cap_word[k], cap_idx[k], e[k*32 +: 32], k);
            else pass_cnt++;
        end
        chk_cnt++;
        if (cap_unstable != 0) $display("FAIL bp_stable: %0d unstable held cycles, required 0", cap_unstable);
        else pass_cnt++;
        chk_cnt++;
        if (cap_rdy_bad != 0) $display("FAIL bp_pkt_ready: high in %0d busy cycles, required 0", cap_rdy_bad);
        else pass_cnt++;
        chk_cnt++;
        if (sent_cnt !== ref_sent || drop_cnt !== ref_drop)
            $display("FAIL bp_counters: sent=%0d drop=%0d, required %0d %0d", sent_cnt, drop_cnt, ref_sent, ref_drop);
        else pass_cnt++;
        $display("backpressure: %0d words in %0d cycles, sent_cnt=%0d", cap_n, cap_cycles, sent_cnt);
    endtask

    task automatic test_reset_mid_send();
        pkt_in = rand_pkt(); pkt_valid = 1'b1; word_ready = 1'b0;
        @(negedge clk);
        pkt_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (word_valid === 1'b1 && word_idx === 3'd3) break;
            word_ready = 1'b1;
            @(negedge clk);
        end
        word_ready = 1'b0;
        chk_cnt++;
        if (word_idx !== 3'd3 || word_valid !== 1'b1)
            $display("FAIL rst_mid_setup: idx=%0d valid=%b, required 3 1", word_idx, word_valid);
        else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        chk_cnt++;
        if (word_valid !== 1'b0 || word_idx !== 3'd0 || sent_cnt !== 16'd0 || pkt_ready !== 1'b1)
            $display("FAIL rst_mid_immediate: valid=%b idx=%0d sent=%0d ready=%b, required 0 0 0 1",
                     word_valid, word_idx, sent_cnt, pkt_ready);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        ref_sent = '0; ref_drop = '0;
        @(negedge clk);
        @(negedge clk);
        chk_cnt++;
        if (word_valid !== 1'b0 || pkt_ready !== 1'b1 || sent_cnt !== 16'd0 || drop_cnt !== 16'd0)
            $display("FAIL rst_mid_after: valid=%b ready=%b sent=%0d drop=%0d, required 0 1 0 0",
                     word_valid, pkt_ready, sent_cnt, drop_cnt);
        else pass_cnt++;
        $display("reset_mid_send: idx cleared, sent_cnt=%0d", sent_cnt);
    endtask

    task automatic test_random();
        logic [223:0] p, e;
        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                int n;
                n = $urandom_range(1, 3);
                pkt_in = IDLE_PATTERN; pkt_valid = 1'b1;
                for (int i = 0; i < n; i++) @(negedge clk);
                pkt_valid = 1'b0;
                ref_drop = ref_drop + 16'(n);
                $display("random %0d: %0d idle patterns dropped", it, n);
            end else begin
                p = rand_pkt();
                e = expected_pkt(p);
                run_packet(p, 2, 1'b1);
                chk_cnt++;
                if (cap_timeout) $display("FAIL rand%0d_timeout: got %0d words, required 7", it, cap_n);
                else pass_cnt++;
                for (int k = 0; k < cap_n; k++) begin
                    chk_cnt++;
                    if (cap_word[k] !== e[k*32 +: 32] || cap_idx[k] !== 3'(k) || cap_last[k] !== (k == 6))
                        $display("FAIL rand%0d_word%0d: data=%h idx=%0d last=%b, required %h %0d %b",
                                 it, k, cap_word[k], cap_idx[k], cap_last[k], e[k*32 +: 32], k, (k == 6));
                    else pass_cnt++;
                end
                chk_cnt++;
                if (cap_unstable != 0 || cap_rdy_bad != 0 || cap_latency != EXP_LAT)
                    $display("FAIL rand%0d_handshake: unstable=%0d ready_bad=%0d latency=%0d, required 0 0 %0d",
                             it, cap_unstable, cap_rdy_bad, cap_latency, EXP_LAT);
                else pass_cnt++;
                $display("random %0d: packet %h sent in %0d cycles", it, p[31:0], cap_cycles);
            end
        end
        chk_cnt++;
        if (sent_cnt !== ref_sent || drop_cnt !== ref_drop)
            $display("FAIL rand_counters: sent=%0d drop=%0d, required %0d %0d", sent_cnt, drop_cnt, ref_sent, ref_drop);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [223:0] p0, p1, e1;
        p0 = rand_pkt(); p1 = rand_pkt();
        e1 = expected_pkt(p1);
        run_packet(p0, 0, 1'b0);
        chk_cnt++;
        if (pkt_ready !== 1'b1) $display("FAIL b2b_gap_ready: got %b, required 1", pkt_ready);
        else pass_cnt++;
        run_packet(p1, 0, 1'b0);
        chk_cnt++;
        if (cap_timeout || cap_word[0] !== e1[31:0] || cap_word[6] !== e1[223:192])
            $display("FAIL b2b_second: words=%0d w0=%h w6=%h, required 7 %h %h", cap_n, cap_word[0], cap_word[6], e1[31:0], e1[223:192]);
        else pass_cnt++;
        chk_cnt++;
        if (cap_cycles != EXP_LAT + 7 || sent_cnt !== ref_sent)
            $display("FAIL b2b_timing: cycles=%0d sent=%0d, required %0d %0d", cap_cycles, sent_cnt, EXP_LAT + 7, ref_sent);
        else pass_cnt++;
        $display("back_to_back: two packets, sent_cnt=%0d", sent_cnt);
    endtask

`ifdef TCP_SER_CSUM_EN
    task automatic test_csum();
        logic [223:0] p;
        p = '0;
        p[15:0] = 16'h0001;
        run_packet(p, 0, 1'b0);
        chk_cnt++;
        if (cap_word[4][31:16] !== 16'hFFFE) $display("FAIL csum_field: got %h, required FFFE", cap_word[4][31:16]);
        else pass_cnt++;
        chk_cnt++;
        if (cap_latency != 15) $display("FAIL csum_latency: got %0d, required 15", cap_latency);
        else pass_cnt++;
        $display("csum: checksum %h, latency %0d", cap_word[4][31:16], cap_latency);
    endtask
`endif

    task automatic test_wrap();
        force dut.sent_cnt_reg = 16'hFFFF;
        @(negedge clk);
        release dut.sent_cnt_reg;
        @(negedge clk);
        chk_cnt++;
        if (sent_cnt !== 16'hFFFF) $display("FAIL wrap_preload: got %h, required FFFF", sent_cnt);
        else pass_cnt++;
        ref_sent = 16'hFFFF;
        run_packet(rand_pkt(), 0, 1'b0);
        chk_cnt++;
        if (sent_cnt !== 16'd0 || ref_sent !== 16'd0 || drop_cnt !== ref_drop)
            $display("FAIL wrap_sent: sent=%h drop=%0d, required 0000 %0d", sent_cnt, drop_cnt, ref_drop);
        else pass_cnt++;
        $display("wrap: sent_cnt=%h", sent_cnt);
    endtask

    initial begin
        test_reset();
        test_drop();
        test_sequential();
        test_backpressure();
        test_reset_mid_send();
        test_random();
        test_back_to_back();
`ifdef TCP_SER_CSUM_EN
        test_csum();
`endif
        test_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
